// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Segment codes are logical (active-high), bit order {g,f,e,d,c,b,a}.
package seven_seg_scan_pkg;

    localparam int N_DIGITS = 7;
    localparam int DP_INDEX = 3;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Physical display bus: shared segments, decimal point, per-digit anodes
// and the snapshot strobe.
interface seven_seg_scan_if;
    import seven_seg_scan_pkg::*;

    logic [6:0]          seg;
    logic                dp;
    logic [N_DIGITS-1:0] an;
    logic                frame_done;

    modport master (output seg, dp, an, frame_done);
    modport slave  (input  seg, dp, an, frame_done);

endinterface

// File: rtl/seven_seg_scan_seg7_decode.sv
// Combinational 8-bit digit code to logical seven-segment pattern.
// Codes outside 0..9 show a dash.
module seg7_decode
    import seven_seg_scan_pkg::*;
(
    input  logic [7:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            8'd0:    seg = SEG_0;
            8'd1:    seg = SEG_1;
            8'd2:    seg = SEG_2;
            8'd3:    seg = SEG_3;
            8'd4:    seg = SEG_4;
            8'd5:    seg = SEG_5;
            8'd6:    seg = SEG_6;
            8'd7:    seg = SEG_7;
            8'd8:    seg = SEG_8;
            8'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Seven-digit time-multiplexed display driver with dead time,
// leading-zero blanking, fixed decimal point and per-frame snapshots.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEAD_CYCLES = 500,
    parameter int LZ_BLANK    = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       min_zehner,
    input  logic [7:0]       min_einer,
    input  logic [7:0]       sek_zehner,
    input  logic [7:0]       sek_einer,
    input  logic [7:0]       sek_zehntel,
    input  logic [7:0]       sek_hundertstel,
    input  logic [7:0]       sek_tausendstel,
    seven_seg_scan_if.master disp
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

    localparam logic [6:0] SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_INV  = (ACTIVE_LOW != 0);

    if (DIV < 4) begin : g_bad_div
        $error("seven_seg_scan: CLK_HZ/SCAN_HZ must be at least 4");
    end
    if (DEAD_CYCLES >= DIV) begin : g_bad_dead
        $error("seven_seg_scan: DEAD_CYCLES must be below CLK_HZ/SCAN_HZ");
    end

    logic [7:0]       digits [N_DIGITS];
    logic [7:0]       snap_q [N_DIGITS];
    logic [7:0]       snap_d [N_DIGITS];
    state_t           state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       seg_q, seg_d;
    logic [6:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             fd_q, fd_d;
    logic [6:0]       seg_logic;
    logic [2:0]       lz;
    logic             blank;

    assign digits[0] = min_zehner;
    assign digits[1] = min_einer;
    assign digits[2] = sek_zehner;
    assign digits[3] = sek_einer;
    assign digits[4] = sek_zehntel;
    assign digits[5] = sek_hundertstel;
    assign digits[6] = sek_tausendstel;

    seg7_decode u_decode (
        .code (snap_q[index_q]),
        .seg  (seg_logic)
    );

    // A leading digit blanks only if every higher-order digit is blank too
    assign lz[0] = (LZ_BLANK != 0) && (snap_q[0] == 8'd0);
    assign lz[1] = lz[0] && (snap_q[1] == 8'd0);
    assign lz[2] = lz[1] && (snap_q[2] == 8'd0);
    assign blank = (index_q < 3'd3) ? lz[index_q[1:0]] : 1'b0;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fd_d    = 1'b0;
        seg_d   = SEG_INV;
        an_d    = SEG_INV;
        dp_d    = DP_INV;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    snap_d  = digits;
                    index_d = 3'd0;
                    cnt_d   = '0;
                    fd_d    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    index_d = 3'd0;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q >= CNT_DEAD && !blank) begin
                        an_d  = SEG_INV ^ (7'h40 >> index_q);
                        seg_d = SEG_INV ^ seg_logic;
                        dp_d  = DP_INV ^ (index_q == 3'(DP_INDEX));
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (index_q == 3'(N_DIGITS - 1)) begin
                            index_d = 3'd0;
                            snap_d  = digits;
                            fd_d    = 1'b1;
                        end else begin
                            index_d = index_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= 3'd0;
            cnt_q   <= '0;
            seg_q   <= SEG_INV;
            an_q    <= SEG_INV;
            dp_q    <= DP_INV;
            fd_q    <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) snap_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
            snap_q  <= snap_d;
        end
    end

    assign disp.seg        = seg_q;
    assign disp.an         = an_q;
    assign disp.dp         = dp_q;
    assign disp.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIV = 10 and two dead cycles.
// Edge k counts rising edges after the one that starts a scan.
module tb_seven_seg_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] mz, me, sz, se, s1, s2, s3;
    int         errors = 0;
    int         checks = 0;
    int         edge_k = 0;

    seven_seg_scan_if disp ();

    seven_seg_scan #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .DEAD_CYCLES (2),
        .LZ_BLANK    (1),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .min_zehner      (mz),
        .min_einer       (me),
        .sek_zehner      (sz),
        .sek_einer       (se),
        .sek_zehntel     (s1),
        .sek_hundertstel (s2),
        .sek_tausendstel (s3),
        .disp            (disp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_edge(input int k);
        step(k - edge_k);
        edge_k = k;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [7:0] a, b, c, d, e, f, g);
        mz = a; me = b; sz = c; se = d; s1 = e; s2 = f; s3 = g;
    endtask

    task automatic start_scan();
        enable = 1'b1;
        step(1);
        edge_k = 0;
    endtask

    task automatic stop_scan();
        enable = 1'b0;
        step(2);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        set_digits(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        step(3);
        chk("rst_seg", disp.seg, 7'h7F);
        chk("rst_an", disp.an, 7'h7F);
        chk("rst_dp", disp.dp, 1'b1);
        chk("rst_fd", disp.frame_done, 1'b0);
        reset = 1'b0;
        step(2);
        chk("idle_an", disp.an, 7'h7F);
        chk("idle_fd", disp.frame_done, 1'b0);

        // digits 1..7
        start_scan();
        chk("s2_fd_first", disp.frame_done, 1'b1);
        chk("s2_an_e0", disp.an, 7'h7F);
        to_edge(1);
        chk("s2_fd_drop", disp.frame_done, 1'b0);
        to_edge(2);
        chk("s2_dead0", disp.an, 7'h7F);
        to_edge(3);
        chk("s2_slot0_an", disp.an, 7'h3F);
        chk("s2_slot0_seg", disp.seg, 7'h79);
        chk("s2_slot0_dp", disp.dp, 1'b1);
        to_edge(10);
        chk("s2_slot0_hold", disp.an, 7'h3F);
        to_edge(11);
        chk("s2_slot1_dead", disp.an, 7'h7F);
        to_edge(31);
        chk("s2_slot3_dead_dp", disp.dp, 1'b1);
        to_edge(33);
        chk("s2_slot3_an", disp.an, 7'h77);
        chk("s2_slot3_seg", disp.seg, 7'h19);
        chk("s2_slot3_dp", disp.dp, 1'b0);
        to_edge(69);
        chk("s2_fd_69", disp.frame_done, 1'b0);
        to_edge(70);
        chk("s2_fd_70", disp.frame_done, 1'b1);
        to_edge(139);
        chk("s2_fd_139", disp.frame_done, 1'b0);
        to_edge(140);
        chk("s2_fd_140", disp.frame_done, 1'b1);
        stop_scan();

        // all zeros
        set_digits(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        start_scan();
        to_edge(3);
        chk("s3_slot0_an", disp.an, 7'h7F);
        to_edge(13);
        chk("s3_slot1_an", disp.an, 7'h7F);
        to_edge(23);
        chk("s3_slot2_an", disp.an, 7'h7F);
        chk("s3_slot2_seg", disp.seg, 7'h7F);
        to_edge(33);
        chk("s3_slot3_an", disp.an, 7'h77);
        chk("s3_slot3_seg", disp.seg, 7'h40);
        chk("s3_slot3_dp", disp.dp, 1'b0);
        to_edge(43);
        chk("s3_slot4_an", disp.an, 7'h7B);
        chk("s3_slot4_seg", disp.seg, 7'h40);
        stop_scan();

        // partial leading zeros
        set_digits(8'd0, 8'd5, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        start_scan();
        to_edge(3);
        chk("s4_slot0_an", disp.an, 7'h7F);
        to_edge(13);
        chk("s4_slot1_an", disp.an, 7'h5F);
        chk("s4_slot1_seg", disp.seg, 7'h12);
        to_edge(23);
        chk("s4_slot2_an", disp.an, 7'h6F);
        chk("s4_slot2_seg", disp.seg, 7'h40);
        stop_scan();

        // dash code and snapshot isolation
        set_digits(8'd1, 8'd2, 8'd3, 8'd4, 8'h0A, 8'd6, 8'd7);
        start_scan();
        to_edge(33);
        me = 8'd9;
        s3 = 8'd3;
        to_edge(43);
        chk("s5_slot4_an", disp.an, 7'h7B);
        chk("s5_slot4_seg", disp.seg, 7'h3F);
        to_edge(63);
        chk("s5_slot6_old", disp.seg, 7'h78);
        to_edge(73);
        chk("s5_f2_slot0", disp.seg, 7'h79);
        to_edge(83);
        chk("s5_f2_slot1", disp.seg, 7'h10);
        stop_scan();

        // enable drop, then reset mid-frame
        set_digits(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        start_scan();
        to_edge(53);
        chk("s6_slot5_an", disp.an, 7'h7D);
        enable = 1'b0;
        step(1);
        chk("s6_off_an", disp.an, 7'h7F);
        chk("s6_off_seg", disp.seg, 7'h7F);
        chk("s6_off_dp", disp.dp, 1'b1);
        step(3);
        chk("s6_idle_an", disp.an, 7'h7F);
        start_scan();
        chk("s6_re_fd", disp.frame_done, 1'b1);
        to_edge(3);
        chk("s6_re_slot0", disp.an, 7'h3F);
        to_edge(25);
        chk("s6_slot2_an", disp.an, 7'h6F);
        reset = 1'b1;
        step(1);
        chk("s6_rst_an", disp.an, 7'h7F);
        chk("s6_rst_seg", disp.seg, 7'h7F);
        chk("s6_rst_fd", disp.frame_done, 1'b0);
        step(2);
        chk("s6_rst_hold", disp.an, 7'h7F);
        reset = 1'b0;
        step(1);
        edge_k = 0;
        chk("s6_rel_fd", disp.frame_done, 1'b1);
        to_edge(3);
        chk("s6_rel_an", disp.an, 7'h3F);
        chk("s6_rel_seg", disp.seg, 7'h79);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Downstream consumer of the timer application's BCD digit bytes: min_zehner, min_einer, sek_zehner, sek_einer, sek_zehntel, sek_hundertstel, sek_tausendstel.
- Time-multiplexes the seven digits onto one shared 7-segment bus with per-digit anode enables.
- Provides anti-ghosting dead time, leading-zero blanking, a fixed decimal point and tear-free frame snapshots.
- Sits between the timer block and the board pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SCAN_HZ, 1000, digit-slot rate; DIV = CLK_HZ/SCAN_HZ cycles per slot. Elaboration error if DIV < 4.
- DEAD_CYCLES, 500, blank cycles at the start of each slot. Must be < DIV.
- LZ_BLANK, 1, 1 = suppress leading zeros on min_zehner, min_einer, sek_zehner.
- ACTIVE_LOW, 1, 1 = seg, dp and an outputs are driven inverted.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = scanning, 0 = display dark
- min_zehner, min_einer, sek_zehner, sek_einer, sek_zehntel, sek_hundertstel, sek_tausendstel  in  8 each  digit codes; valid 0..9
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  7  anode enables; an[6] = min_zehner (leftmost) ... an[0] = sek_tausendstel
- frame_done  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values (logical): seg, dp and an all inactive (all 1 when ACTIVE_LOW = 1); frame_done = 0; state = IDLE; index = 0; slot_cnt = 0; snapshot = all 0.
- State machine:
  - IDLE: outputs inactive. When enable = 1: snapshot all inputs, index <= 0, slot_cnt <= 0, pulse frame_done, go to SCAN.
  - SCAN: slot_cnt counts 0..DIV-1.
    - At DIV-1: slot_cnt <= 0 and index increments.
    - When index = 6 at DIV-1: index <= 0, re-snapshot all inputs, frame_done = 1 for that one cycle.
    - enable = 0 in SCAN: go to IDLE next cycle. Outputs inactive from that cycle; counters clear.
- Slot content:
  - slot_cnt < DEAD_CYCLES: all anodes and segments inactive.
  - Otherwise: an[6-index] active; seg/dp from the snapshot digit at index.
- Frame timing: slot = DIV cycles; frame = 7*DIV cycles.
- Outputs are registered. They reflect index/slot_cnt of the previous cycle (1-cycle latency).
- Decode uses the full 8-bit code; logical (active-high) values:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Any code > 9 displays a dash, 0x40.
- Leading-zero blanking (LZ_BLANK = 1):
  - A digit at index 0..2 is blanked when it and every higher-order digit in the snapshot are 0.
  - A blanked digit drives anode and segments inactive for the whole slot.
  - sek_einer and lower digits are never blanked.
- dp is active only in the sek_einer slot (index 3), and only outside dead time.
- Input changes mid-frame have no effect until the next snapshot.
- reset and enable together: reset wins.

Decomposition:
- Shared package: segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF), N_DIGITS = 7, DP_INDEX = 3.
- One sub-module: seg7_decode — combinational 8-bit code to 7-bit logical segments, including the dash rule. It is reused later by other display blocks.

Test Plan:
All scenarios use CLK_HZ = 1000, SCAN_HZ = 100 (DIV = 10), DEAD_CYCLES = 2, ACTIVE_LOW = 1.
1. Reset asserted for 3 cycles -> seg = 7'h7F, an = 7'h7F, dp = 1, frame_done = 0 while enable = 0.
2. Digits 1,2,3,4,5,6,7, enable raised -> frame_done pulses once.
   - In slot 0 after 2 dead cycles: an = 7'h3F, seg = 7'h79, held 8 cycles.
   - Slot 3: an = 7'h77, seg = ~0x66 = 7'h19, dp = 0.
   - frame_done repeats every 70 cycles.
3. All digits 0 -> an stays 7'h7F for slots 0..2; slot 3 shows seg = 7'h40, dp = 0.
4. min_zehner = 0, min_einer = 5, sek_zehner = 0 -> slot 0 blank. Slot 1 seg = 7'h12. Slot 2 shows 0 (seg = 7'h40), because a higher-order digit is nonzero.
5. sek_zehntel = 8'h0A, then min_einer changed to 9 during slot 3 -> slot 4 seg = 7'h3F (dash). Slot 1 keeps its old value until after the next frame_done.
6. enable dropped during slot 5, and separately reset asserted mid-frame -> outputs all 1 on the next edge. After re-enable, the scan restarts at slot 0 with a frame_done pulse.
